// File: rtl/sram_banked_pkg.sv
// Shared types and helpers for the banked bit-enable SRAM wrapper.
package sram_banked_pkg;

    localparam int unsigned DefaultWidth = 78;
    localparam int unsigned DefaultDepth = 512;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        INIT       = 2'd1,
        IDLE       = 2'd2
    } sram_state_e;

    // Bank-index width; a single bank still needs a one-bit select signal.
    function automatic int unsigned bank_idx_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/sram_banked_be_bank.sv
// Behavioural stand-in for one hard bit-enable SRAM bank: 1-cycle registered read.
module sram_bank_model #(
    parameter int unsigned Width = 78,
    parameter int unsigned Depth = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 ren_i,
    input  logic                                 wen_i,
    input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] adr_i,
    input  logic [Width-1:0]                     din_i,
    input  logic [Width-1:0]                     wbeb_i,
    output logic [Width-1:0]                     q_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] wr_word;
    logic [Width-1:0] q_q;
    logic [Width-1:0] q_d;

    // wbeb is active-low: a 1 keeps the stored bit.
    always_comb begin
        wr_word = (mem_q[adr_i] & wbeb_i) | (din_i & ~wbeb_i);
        q_d     = q_q;
        if (ren_i) begin
            q_d = mem_q[adr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            mem_q[adr_i] <= wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sram_banked_be.sv
// Banked single-port SRAM with bit write enables, req/gnt/rvalid front end
// and a zeroisation sequencer that clears every bank row-by-row in parallel.
module sram_banked_be
    import sram_banked_pkg::*;
#(
    parameter int unsigned Width    = DefaultWidth,
    parameter int unsigned Depth    = DefaultDepth,
    parameter int unsigned NumBanks = 2,
    parameter int unsigned OutReg   = 0,
    parameter int unsigned InitZero = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [Width-1:0]         wmask_i,
    output logic                     rvalid_o,
    output logic [Width-1:0]         rdata_o,
    input  logic                     init_req_i,
    output logic                     init_done_o
);

    localparam int unsigned AW       = $clog2(Depth);
    localparam int unsigned BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 0;
    localparam int unsigned BW       = bank_idx_w(NumBanks);
    localparam int unsigned RowDepth = Depth / NumBanks;
    localparam int unsigned RowW     = (RowDepth > 1) ? $clog2(RowDepth) : 1;

    sram_state_e         state_q, state_d;
    logic [RowW-1:0]     cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                rvalid1_q, rvalid1_d;
    logic [BW-1:0]       sel_q, sel_d;

    logic [BW-1:0]       bank_idx;
    logic [RowW-1:0]     row;
    logic                rd_acc;
    logic [NumBanks-1:0] bank_ren;
    logic [NumBanks-1:0] bank_wen;
    logic [RowW-1:0]     bank_adr;
    logic [Width-1:0]    bank_din;
    logic [Width-1:0]    bank_wbeb;
    logic [Width-1:0]    bank_q [NumBanks];
    logic [Width-1:0]    rd_mux;

    // Low address bits interleave banks; the rest pick the row.
    always_comb begin
        bank_idx = BW'(addr_i & AW'(NumBanks - 1));
        row      = RowW'(addr_i >> BankBits);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_o     = 1'b0;
        rd_acc    = 1'b0;
        bank_ren  = '0;
        bank_wen  = '0;
        bank_adr  = row;
        bank_din  = wdata_i;
        bank_wbeb = ~wmask_i;

        case (state_q)
            RESET_WAIT: begin
                cnt_d   = '0;
                state_d = (InitZero != 0) ? INIT : IDLE;
            end
            INIT: begin
                bank_wen  = '1;
                bank_adr  = cnt_q;
                bank_din  = '0;
                bank_wbeb = '0;
                if (cnt_q == RowW'(RowDepth - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + RowW'(1);
                end
            end
            IDLE: begin
                if (init_req_i) begin
                    cnt_d   = '0;
                    state_d = INIT;
                end else begin
                    gnt_o = 1'b1;
                    if (req_i) begin
                        if (we_i) begin
                            bank_wen = NumBanks'(1) << bank_idx;
                        end else begin
                            bank_ren = NumBanks'(1) << bank_idx;
                            rd_acc   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase

        init_done_d = (state_d == IDLE);
        rvalid1_d   = rd_acc;
        sel_d       = rd_acc ? bank_idx : sel_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RESET_WAIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rvalid1_q   <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rvalid1_q   <= rvalid1_d;
            sel_q       <= sel_d;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        sram_bank_model #(
            .Width (Width),
            .Depth (RowDepth)
        ) u_bank (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .ren_i  (bank_ren[b]),
            .wen_i  (bank_wen[b]),
            .adr_i  (bank_adr),
            .din_i  (bank_din),
            .wbeb_i (bank_wbeb),
            .q_o    (bank_q[b])
        );
    end

    // Bank q registers hold between reads, so the steered mux holds too.
    assign rd_mux = bank_q[sel_q];

    if (OutReg != 0) begin : g_oreg
        logic             rvalid2_q, rvalid2_d;
        logic [Width-1:0] rdata_q, rdata_d;

        always_comb begin
            rvalid2_d = rvalid1_q;
            rdata_d   = rvalid1_q ? rd_mux : rdata_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid2_q <= 1'b0;
                rdata_q   <= '0;
            end else begin
                rvalid2_q <= rvalid2_d;
                rdata_q   <= rdata_d;
            end
        end

        assign rvalid_o = rvalid2_q;
        assign rdata_o  = rdata_q;
    end else begin : g_noreg
        assign rvalid_o = rvalid1_q;
        assign rdata_o  = rd_mux;
    end

    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_sram_banked_be.sv
// Directed self-checking bench for sram_banked_be (default parameters, OutReg=0).
module tb_sram_banked_be;

    localparam int unsigned W  = 78;
    localparam int unsigned D  = 512;
    localparam int unsigned AW = 9;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_i;
    logic          gnt_o;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [W-1:0]  wdata_i;
    logic [W-1:0]  wmask_i;
    logic          rvalid_o;
    logic [W-1:0]  rdata_o;
    logic          init_req_i;
    logic          init_done_o;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] pat_a;
    logic [W-1:0] pat_b;
    logic [W-1:0] pat_c;
    logic [W-1:0] ones;

    always #5 clk_i = ~clk_i;

    sram_banked_be #(
        .Width    (W),
        .Depth    (D),
        .NumBanks (2),
        .OutReg   (0),
        .InitZero (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wmask_i     (wmask_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .init_req_i  (init_req_i),
        .init_done_o (init_done_o)
    );

    task automatic drive_idle();
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        wmask_i    = '0;
        init_req_i = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        wmask_i = m;
        @(posedge clk_i);
        #1;
        drive_idle();
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic v, output logic [W-1:0] q);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        @(posedge clk_i);
        #1;
        v = rvalid_o;
        q = rdata_o;
        drive_idle();
    endtask

    // Counts edges until init_done_o rises (bounded); flags any grant seen before then.
    task automatic wait_init(output int n, output bit gnt_seen);
        n        = 0;
        gnt_seen = 1'b0;
        while (n < 600) begin
            @(posedge clk_i);
            #1;
            n++;
            if (init_done_o) break;
            if (gnt_o) gnt_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_ni = 1'b0;
        #22;
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
        checks++; if (rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done_o); end
    endtask

    task automatic test_init_after_reset();
        int n;
        bit gs;
        logic v;
        logic [W-1:0] q;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        wait_init(n, gs);
        checks++; if (n !== 257) begin errors++; $display("FAIL init_len: got %0d edges want 257", n); end
        checks++; if (gs !== 1'b0) begin errors++; $display("FAIL init_no_gnt: gnt seen %b want 0", gs); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL idle_gnt: got %b want 1", gnt_o); end
        do_read(9'd0, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL init_zero_a0: got v=%b %h want v=1 0", v, q); end
        do_read(9'd511, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL init_zero_a511: got v=%b %h want v=1 0", v, q); end
    endtask

    task automatic test_mask();
        logic v;
        logic [W-1:0] q;
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
        logic [W-1:0] top;
        exp1 = 78'h3FF_FFFF_FFFF_FFFF_FF00;
        top  = W'(1) << 77;
        exp2 = exp1 | top;
        do_write(9'd5, 78'h3FF_FFFF_FFFF_FFFF_FFFF, ones);
        do_write(9'd5, '0, 78'hFF);
        do_read(9'd5, v, q);
        checks++; if (v !== 1'b1 || q !== exp1) begin errors++; $display("FAIL mask_low: got v=%b %h want v=1 %h", v, q, exp1); end
        do_write(9'd5, ones, top);
        checks++; if (rvalid_o !== 1'b0 || rdata_o !== exp1) begin errors++; $display("FAIL rdata_hold: got v=%b %h want v=0 %h", rvalid_o, rdata_o, exp1); end
        do_read(9'd5, v, q);
        checks++; if (v !== 1'b1 || q !== exp2) begin errors++; $display("FAIL mask_top: got v=%b %h want v=1 %h", v, q, exp2); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ra [3];
        logic [W-1:0]  re [3];
        do_write(9'd4, pat_a, ones);
        do_write(9'd5, pat_b, ones);
        ra[0] = 9'd4; re[0] = pat_a;
        ra[1] = 9'd5; re[1] = pat_b;
        ra[2] = 9'd4; re[2] = pat_a;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                req_i  = 1'b1;
                we_i   = 1'b0;
                addr_i = ra[c];
            end else begin
                drive_idle();
            end
            @(posedge clk_i);
            #1;
            if (c < 3) begin
                checks++;
                if (rvalid_o !== 1'b1 || rdata_o !== re[c]) begin
                    errors++;
                    $display("FAIL b2b_rd%0d: got v=%b %h want v=1 %h", c, rvalid_o, rdata_o, re[c]);
                end
            end else begin
                checks++;
                if (rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got v=%b want 0", rvalid_o); end
            end
        end
    endtask

    task automatic test_read_after_write();
        logic v;
        logic [W-1:0] q;
        do_write(9'd9, pat_c, ones);
        do_read(9'd9, v, q);
        checks++; if (v !== 1'b1 || q !== pat_c) begin errors++; $display("FAIL raw_a9: got v=%b %h want v=1 %h", v, q, pat_c); end
    endtask

    task automatic test_init_req();
        int n;
        bit gs;
        logic v;
        logic [W-1:0] q;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 9'd4;
        @(posedge clk_i);
        #1;
        drive_idle();
        init_req_i = 1'b1;
        #1;
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== pat_a) begin errors++; $display("FAIL initreq_rvalid: got v=%b %h want v=1 %h", rvalid_o, rdata_o, pat_a); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL initreq_gnt: got %b want 0", gnt_o); end
        @(posedge clk_i);
        #1;
        init_req_i = 1'b0;
        checks++; if (init_done_o !== 1'b0) begin errors++; $display("FAIL initreq_done_clr: got %b want 0", init_done_o); end
        wait_init(n, gs);
        checks++; if (n !== 256 || gs !== 1'b0) begin errors++; $display("FAIL initreq_len: got %0d edges gnt=%b want 256 gnt=0", n, gs); end
        do_read(9'd4, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL initreq_clr4: got v=%b %h want v=1 0", v, q); end
        do_read(9'd5, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL initreq_clr5: got v=%b %h want v=1 0", v, q); end
        do_read(9'd9, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL initreq_clr9: got v=%b %h want v=1 0", v, q); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        bit gs;
        logic v;
        logic [W-1:0] q;
        do_write(9'd4, pat_a, ones);
        do_read(9'd4, v, q);
        checks++; if (v !== 1'b1 || q !== pat_a) begin errors++; $display("FAIL mid_pre_read: got v=%b %h want v=1 %h", v, q, pat_a); end
        init_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        init_req_i = 1'b0;
        repeat (100) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (gnt_o !== 1'b0 || init_done_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got gnt=%b done=%b want 0 0", gnt_o, init_done_o); end
        checks++; if (rvalid_o !== 1'b0 || rdata_o !== '0) begin errors++; $display("FAIL mid_rst_data: got v=%b %h want v=0 0", rvalid_o, rdata_o); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        wait_init(n, gs);
        checks++; if (n !== 257 || gs !== 1'b0) begin errors++; $display("FAIL mid_reinit_len: got %0d edges gnt=%b want 257 gnt=0", n, gs); end
        do_read(9'd4, v, q);
        checks++; if (v !== 1'b1 || q !== '0) begin errors++; $display("FAIL mid_reinit_clr: got v=%b %h want v=1 0", v, q); end
    endtask

    initial begin
        ones  = '1;
        pat_a = 78'h2A5_A5A5_1234_5678_9ABC;
        pat_b = 78'h15A_5A5A_FEDC_BA98_7654;
        pat_c = 78'h0C3_3C3C_DEAD_BEEF_0001;
        test_reset();
        test_init_after_reset();
        test_mask();
        test_back_to_back();
        test_read_after_write();
        test_init_req();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
